// File: rtl/zoi_dump_pkg.sv
// zoi_dump_pkg -- shared types and helpers for the zoi_dump frame transmitter.
//
// Holds the FSM state enum, frame constants, flags-byte bit positions, the
// captured snapshot layout, and the two pure functions that turn a snapshot
// into frame bytes: frame_byte() selects the byte for an index, and
// frame_checksum() XORs bytes 0..12.

package zoi_dump_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam logic [7:0] HEADER    = 8'hA5;
   localparam int         FRAME_LEN = 14;
   localparam int         IDX_W     = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   // Bit positions inside the flags byte (upper nibble is always zero).
   localparam int FLAG_REG_WRITE  = 0;
   localparam int FLAG_MEM_TO_REG = 1;
   localparam int FLAG_BRANCH     = 2;
   localparam int FLAG_MEM_WRITE  = 3;

   // One captured observation, already laid out in wire-byte terms.
   typedef struct packed {
      logic [7:0]  pc;
      logic [31:0] instruction;
      logic [7:0]  src_a;
      logic [7:0]  src_b;
      logic [7:0]  alu_result;
      logic [7:0]  result;
      logic [7:0]  write_data;
      logic [7:0]  read_data;
      logic [7:0]  flags;
      logic [7:0]  checksum;
   } snapshot_t;

   function automatic logic [7:0] frame_byte(input snapshot_t s,
                                             input logic [IDX_W-1:0] idx);
      logic [7:0] b;
      case (idx)
         4'd0:    b = HEADER;
         4'd1:    b = s.pc;
         4'd2:    b = s.instruction[7:0];
         4'd3:    b = s.instruction[15:8];
         4'd4:    b = s.instruction[23:16];
         4'd5:    b = s.instruction[31:24];
         4'd6:    b = s.src_a;
         4'd7:    b = s.src_b;
         4'd8:    b = s.alu_result;
         4'd9:    b = s.result;
         4'd10:   b = s.write_data;
         4'd11:   b = s.read_data;
         4'd12:   b = s.flags;
         4'd13:   b = s.checksum;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // XOR of the header and every payload byte; the stored checksum field
   // itself is never part of the sum.
   function automatic logic [7:0] frame_checksum(input snapshot_t s);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < FRAME_LEN - 1; i++) begin
         acc ^= frame_byte(s, IDX_W'(i));
      end
      return acc;
   endfunction

endpackage

// File: rtl/zoi_dump.sv
// zoi_dump -- frame transmitter for CPU observation data.
//
// On a single-step pulse the observed CPU signals are captured into a
// snapshot (checksum included) and sent as a fixed 14-byte frame over a
// valid/ready byte stream. Steps that arrive while a frame is still in
// flight are dropped and counted; a step coinciding with the final-byte
// handshake starts the next frame back-to-back.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   step                 one-cycle capture request
//   pc, instruction,
//   SrcA .. ReadData,
//   MemWrite .. RegWrite observed CPU signals (sampled only on capture)
//   tx_data, tx_valid    outbound byte stream (registered)
//   tx_ready             consumer accepts when tx_valid && tx_ready
//   busy                 frame captured and not yet fully accepted
//   overrun_cnt          saturating count of dropped steps

module zoi_dump
   import zoi_dump_pkg::*;
#(
   parameter int NBITS    = 8,
   parameter int OVR_BITS = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                step,
   input  logic [NBITS-1:0]    pc,
   input  logic [31:0]         instruction,
   input  logic [NBITS-1:0]    SrcA,
   input  logic [NBITS-1:0]    SrcB,
   input  logic [NBITS-1:0]    ALUResult,
   input  logic [NBITS-1:0]    Result,
   input  logic [NBITS-1:0]    WriteData,
   input  logic [NBITS-1:0]    ReadData,
   input  logic                MemWrite,
   input  logic                Branch,
   input  logic                MemtoReg,
   input  logic                RegWrite,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy,
   output logic [OVR_BITS-1:0] overrun_cnt
);

   state_e              state_q,       state_d;
   logic [IDX_W-1:0]    idx_q,         idx_d;
   snapshot_t           snap_q,        snap_d;
   logic [7:0]          tx_data_q,     tx_data_d;
   logic                tx_valid_q,    tx_valid_d;
   logic                busy_q,        busy_d;
   logic [OVR_BITS-1:0] overrun_cnt_q, overrun_cnt_d;

   snapshot_t           capture;
   logic                handshake;
   logic                last_handshake;

   // Snapshot as it would be captured this cycle, checksum precomputed so
   // it never has to be recomputed while bytes are going out.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      capture             = '0;
      capture.pc          = pc;
      capture.instruction = instruction;
      capture.src_a       = SrcA;
      capture.src_b       = SrcB;
      capture.alu_result  = ALUResult;
      capture.result      = Result;
      capture.write_data  = WriteData;
      capture.read_data   = ReadData;
      capture.flags[FLAG_REG_WRITE]  = RegWrite;
      capture.flags[FLAG_MEM_TO_REG] = MemtoReg;
      capture.flags[FLAG_BRANCH]     = Branch;
      capture.flags[FLAG_MEM_WRITE]  = MemWrite;
      capture.checksum    = frame_checksum(capture);
   end

   assign handshake      = tx_valid_q && tx_ready;
   assign last_handshake = handshake && (idx_q == LAST_IDX);

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      snap_d        = snap_q;
      overrun_cnt_d = overrun_cnt_q;

      case (state_q)
         IDLE: begin
            if (step) begin
               snap_d  = capture;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (last_handshake) begin
               idx_d = '0;
               if (step) begin
                  // Back-to-back: next frame starts without an IDLE cycle.
                  snap_d = capture;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (handshake) begin
                  idx_d = idx_q + 1'b1;
               end
               if (step && (overrun_cnt_q != '1)) begin
                  overrun_cnt_d = overrun_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are derived from next state so they can be registered
      // without adding a cycle of latency after the step.
      tx_valid_d = (state_d == SEND);
      busy_d     = (state_d == SEND);
      tx_data_d  = (state_d == SEND) ? frame_byte(snap_d, idx_d) : 8'h00;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         // NOTE: the snapshot register is cleared on reset too, so a fresh
         // block never exposes stale capture contents.
         snap_q        <= '0;
         tx_data_q     <= 8'h00;
         tx_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
         overrun_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         snap_q        <= snap_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         busy_q        <= busy_d;
         overrun_cnt_q <= overrun_cnt_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign busy        = busy_q;
   assign overrun_cnt = overrun_cnt_q;

endmodule
